sram_march_bist: RTL and testbench

March C- built-in self-test sequencer for a single-port, byte-masked, 1-cycle-read-latency SRAM macro (default 1024x32, 8-bit write granularity). Sits between the BIST/scan control registers and the macro's clk/we/wmask/addr/din/dout pins. Sequences every address through the March C- elements, compares read data one cycle after each read, and reports pass/fail with first-failure capture.

---
 rtl/sram_march_bist.sv | 207 ++++++++++++++++++++
 tb/tb_sram_march_bist.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : sram_march_bist
// Description : March C- BIST sequencer for a single-port, byte-masked SRAM
//               macro with one cycle of read latency. Issues one macro op per
//               cycle (10 x depth ops), checks each read one cycle after the
//               macro samples it and captures the first mismatch.
// Ports       : clk, rstb (sync, active low)
//               start, bg_pattern            - test control / background word
//               busy, done, fail             - status (done and fail sticky)
//               fail_addr/data/expected      - first-mismatch capture
//               sram_we/wmask/addr/din       - registered macro controls
//               sram_dout                    - macro read data
// Options     : SRAM_BIST_STOP_ON_FAIL_EN - end the test on the first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module sram_march_bist #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  bg_pattern,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_WIDTH-1:0]  fail_addr,
    output logic [DATA_WIDTH-1:0]  fail_data,
    output logic [DATA_WIDTH-1:0]  fail_expected,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_ADDR_MAX = '1;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_pat;
    // Op cursor: always points at the next op to be presented.
    logic [2:0]            r_elem;
    logic                  r_phase;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_issue_done;
    // Stage 1: read presented to the macro; stage 2: dout valid, compare.
    logic                  r_rd_valid, r_rd_last;
    logic [DATA_WIDTH-1:0] r_rd_exp;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_cmp_valid, r_cmp_last;
    logic [DATA_WIDTH-1:0] r_cmp_exp;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;

    logic                  w_down, w_single, w_is_read, w_invert;
    logic                  w_addr_step, w_elem_end, w_last_op, w_next_down;
    logic                  w_issue, w_mismatch;
    logic [DATA_WIDTH-1:0] w_pat, w_op_data;

    always_comb begin
        // On the accepting edge the pattern is not registered yet.
        w_pat       = (r_state == c_RUN) ? r_pat : bg_pattern;
        w_down      = (r_elem == 3'd3) || (r_elem == 3'd4);
        w_single    = (r_elem == 3'd0) || (r_elem == 3'd5);
        w_is_read   = (r_elem != 3'd0) && (w_single || !r_phase);
        // Reads of M2/M4 expect ~P; writes of M1/M3 store ~P.
        w_invert    = w_is_read ? ((r_elem == 3'd2) || (r_elem == 3'd4))
                                : ((r_elem == 3'd1) || (r_elem == 3'd3));
        w_op_data   = w_invert ? ~w_pat : w_pat;
        w_addr_step = w_single || r_phase;
        w_elem_end  = w_down ? (r_addr == '0) : (r_addr == c_ADDR_MAX);
        w_last_op   = (r_elem == 3'd5) && w_elem_end;
        w_next_down = (r_elem == 3'd2) || (r_elem == 3'd3);
        w_issue     = (r_state == c_RUN) ? !r_issue_done : start;
        w_mismatch  = (r_state == c_RUN) && r_cmp_valid && (sram_dout != r_cmp_exp);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state       <= c_IDLE;
            r_pat         <= '0;
            r_elem        <= '0;
            r_phase       <= 1'b0;
            r_addr        <= '0;
            r_issue_done  <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
            r_rd_exp      <= '0;
            r_rd_addr     <= '0;
            r_cmp_valid   <= 1'b0;
            r_cmp_last    <= 1'b0;
            r_cmp_exp     <= '0;
            r_cmp_addr    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_addr     <= '0;
            fail_data     <= '0;
            fail_expected <= '0;
            sram_we       <= 1'b0;
            sram_wmask    <= '0;
            sram_addr     <= '0;
            sram_din      <= '0;
        end else begin
            // Issue stage
            if (w_issue) begin
                sram_we    <= !w_is_read;
                sram_wmask <= w_is_read ? '0 : '1;
                sram_addr  <= r_addr;
                sram_din   <= w_is_read ? '0 : w_op_data;
                r_rd_valid <= w_is_read;
                r_rd_last  <= w_last_op;
                r_rd_exp   <= w_op_data;
                r_rd_addr  <= r_addr;
                if (w_addr_step) begin
                    r_phase <= 1'b0;
                    if (w_elem_end) begin
                        if (r_elem == 3'd5) begin
                            r_elem       <= '0;
                            r_addr       <= '0;
                            r_issue_done <= 1'b1;
                        end else begin
                            // Jump straight to the next element's first address.
                            r_elem <= r_elem + 3'd1;
                            r_addr <= w_next_down ? c_ADDR_MAX : '0;
                        end
                    end else begin
                        r_addr <= w_down ? r_addr - 1'b1 : r_addr + 1'b1;
                    end
                end else begin
                    r_phase <= 1'b1;
                end
            end else begin
                sram_we    <= 1'b0;
                sram_wmask <= '0;
                sram_addr  <= '0;
                sram_din   <= '0;
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end

            // Compare stage lines up with the macro's dout
            r_cmp_valid <= r_rd_valid;
            r_cmp_last  <= r_rd_last;
            r_cmp_exp   <= r_rd_exp;
            r_cmp_addr  <= r_rd_addr;

            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state       <= c_RUN;
                        r_pat         <= bg_pattern;
                        r_issue_done  <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        fail          <= 1'b0;
                        fail_addr     <= '0;
                        fail_data     <= '0;
                        fail_expected <= '0;
                    end
                end
                c_RUN: begin
                    if (w_mismatch && !fail) begin
                        fail          <= 1'b1;
                        fail_addr     <= r_cmp_addr;
                        fail_data     <= sram_dout;
                        fail_expected <= r_cmp_exp;
                    end
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
                    if (w_mismatch || (r_cmp_valid && r_cmp_last)) begin
                        // Abort: drop the in-flight op and park the cursor.
                        r_state      <= c_DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        sram_we      <= 1'b0;
                        sram_wmask   <= '0;
                        sram_addr    <= '0;
                        sram_din     <= '0;
                        r_rd_valid   <= 1'b0;
                        r_rd_last    <= 1'b0;
                        r_cmp_valid  <= 1'b0;
                        r_cmp_last   <= 1'b0;
                        r_elem       <= '0;
                        r_phase      <= 1'b0;
                        r_addr       <= '0;
                        r_issue_done <= 1'b0;
                    end
`else
                    if (r_cmp_valid && r_cmp_last) begin
                        r_state <= c_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
`endif
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_march_bist
// Description : Bench for sram_march_bist at default geometry. A behavioural
//               1-cycle-latency byte-masked SRAM sits on the macro pins; the
//               expected March C- op stream is queued at each start and
//               compared op by op on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_march_bist;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int MW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int N     = 10 * DEPTH;

    logic          clk, rstb, start;
    logic [DW-1:0] bg_pattern;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data, fail_expected;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    sram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) dut (
        .clk(clk), .rstb(rstb), .start(start), .bg_pattern(bg_pattern),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_data(fail_data), .fail_expected(fail_expected),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model; fault_en adds a stuck-at-1 on bit 5 of word 3.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wr_word;
    logic          fault_en;
    always @(posedge clk) begin
        if (sram_we) begin
            wr_word = mem[sram_addr];
            for (int b = 0; b < MW; b++)
                if (sram_wmask[b]) wr_word[b*8 +: 8] = sram_din[b*8 +: 8];
            mem[sram_addr] <= wr_word;
        end
        sram_dout <= (fault_en && sram_addr == AW'(3)) ? (mem[sram_addr] | 32'h20)
                                                        : mem[sram_addr];
    end

    typedef struct packed {
        logic          we;
        logic [MW-1:0] wmask;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;
    op_t q[$];

    int checks = 0;
    int errors = 0;
    logic mon_idle = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input logic we, input int a, input logic [DW-1:0] d);
        op_t o;
        o.we    = we;
        o.wmask = we ? {MW{1'b1}} : {MW{1'b0}};
        o.addr  = a[AW-1:0];
        o.din   = we ? d : '0;
        q.push_back(o);
    endtask

    task automatic push_march(input logic [DW-1:0] p);
        for (int a = 0; a < DEPTH; a++) push_op(1'b1, a, p);
        for (int a = 0; a < DEPTH; a++) begin push_op(1'b0, a, '0); push_op(1'b1, a, ~p); end
        for (int a = 0; a < DEPTH; a++) begin push_op(1'b0, a, '0); push_op(1'b1, a, p); end
        for (int a = DEPTH-1; a >= 0; a--) begin push_op(1'b0, a, '0); push_op(1'b1, a, ~p); end
        for (int a = DEPTH-1; a >= 0; a--) begin push_op(1'b0, a, '0); push_op(1'b1, a, p); end
        for (int a = 0; a < DEPTH; a++) push_op(1'b0, a, '0);
    endtask

    // Op monitor: one queued op per falling edge; idle bus must stay quiet.
    always @(negedge clk) begin
        op_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            check("op", 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'(e));
        end else if (mon_idle && !busy) begin
            check("idle_bus", 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'(0));
        end
    end

    task automatic run_start(input logic [DW-1:0] p);
        bg_pattern = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bg_pattern = ~p;
        push_march(p);
        check("start_status", 64'({busy, done, fail}), 64'(3'b100));
    endtask

    task automatic wait_done(input int pulse_a, input int pulse_b, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == pulse_a) || (cyc == pulse_b);
        end
        start = 1'b0;
    endtask

    task automatic check_mem(input logic [DW-1:0] p);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== p) bad++;
        check("mem_final", 64'(bad), 64'(0));
    endtask

    int cyc;
    int exp_lat;

    initial begin
        rstb = 1'b0; start = 1'b0; bg_pattern = '0; fault_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_status", 64'({busy, done, fail, fail_addr}), 64'(0));
        check("rst_capture", {fail_data, fail_expected}, 64'(0));
        check("rst_bus", 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'(0));
        rstb = 1'b1;
        mon_idle = 1'b1;

        // Clean run; start pulsed mid-run and on the done edge (both ignored)
        run_start(32'hA5A5A5A5);
        wait_done(100, N, cyc);
        check("lat_clean", 64'(cyc), 64'(N + 1));
        check("clean_status", 64'({busy, done, fail}), 64'(3'b010));
        check("clean_ops_left", 64'(q.size()), 64'(0));
        check_mem(32'hA5A5A5A5);
        @(posedge clk); #1;
        check("done_edge_start_ignored", 64'({busy, done}), 64'(2'b01));

        // Faulty run started right after done
        fault_en = 1'b1;
        run_start(32'h00000000);
        wait_done(-1, -1, cyc);
`ifdef SRAM_BIST_STOP_ON_FAIL_EN
        exp_lat = DEPTH + 8;
`else
        exp_lat = N + 1;
        check("fault_ops_left", 64'(q.size()), 64'(0));
`endif
        q.delete();
        check("lat_fault", 64'(cyc), 64'(exp_lat));
        check("fault_status", 64'({busy, done, fail}), 64'(3'b011));
        check("fail_addr", 64'(fail_addr), 64'(3));
        check("fail_data", 64'(fail_data), 64'(32'h00000020));
        check("fail_expected", 64'(fail_expected), 64'(0));
        fault_en = 1'b0;
        @(posedge clk); #1;

        // Reset at op 500 aborts the run
        run_start(32'h12345678);
        repeat (499) @(posedge clk);
        #1;
        rstb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        q.delete();
        check("abort_status", 64'({busy, done, fail}), 64'(0));
        check("abort_bus", 64'({sram_we, sram_wmask, sram_addr, sram_din}), 64'(0));
        @(posedge clk); #1;

        // Clean run after the abort
        run_start(32'h0F0F00FF);
        wait_done(-1, -1, cyc);
        check("lat_after_abort", 64'(cyc), 64'(N + 1));
        check("after_abort_status", 64'({busy, done, fail}), 64'(3'b010));
        check("after_abort_ops_left", 64'(q.size()), 64'(0));
        check_mem(32'h0F0F00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
